// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with write-first bypass and a bulk-clear sequencer.
// Define ZERO_REG_EN to hardwire entry 0 to zero.
module reg_file_2r1w #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b,
    input  logic              clr,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
    logic              rd_valid_a_q, rd_valid_a_d;
    logic              rd_valid_b_q, rd_valid_b_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              wr_ok;

`ifdef ZERO_REG_EN
    assign wr_ok = wr_en && (wr_addr != '0);
`else
    assign wr_ok = wr_en;
`endif

    // Write-first: a same-cycle accepted write wins over the stored word.
    function automatic logic [WIDTH-1:0] rd_word(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] w;
        w = (wr_ok && (wr_addr == a)) ? wr_data : mem_q[a];
`ifdef ZERO_REG_EN
        if (a == '0) w = '0;
`endif
        return w;
    endfunction

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        mem_we       = 1'b0;
        mem_addr     = wr_addr;
        mem_wdata    = wr_data;
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_we = wr_ok;
                if (rd_en_a) begin
                    rd_data_a_d  = rd_word(rd_addr_a);
                    rd_valid_a_d = 1'b1;
                end
                if (rd_en_b) begin
                    rd_data_b_d  = rd_word(rd_addr_b);
                    rd_valid_b_d = 1'b1;
                end
                if (clr) state_d = CLEAR;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomised bench for reg_file_2r1w against an array-based reference model.
// Honours ZERO_REG_EN in the same way as the design.
module tb_reg_file_2r1w;
    localparam int W = 32;
    localparam int A = 5;
    localparam int D = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en_a = 1'b0;
    logic [A-1:0] rd_addr_a = '0;
    logic [W-1:0] rd_data_a;
    logic         rd_valid_a;
    logic         rd_en_b = 1'b0;
    logic [A-1:0] rd_addr_b = '0;
    logic [W-1:0] rd_data_b;
    logic         rd_valid_b;
    logic         clr = 1'b0;
    logic         busy;

    reg_file_2r1w #(.WIDTH(W), .ADDR_W(A)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_mem [D];
    logic         m_busy;
    int           m_left;
    int           m_idx;
    logic [W-1:0] e_da, e_db;
    logic         e_va, e_vb;
    int           checks = 0;
    int           failures = 0;

`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("rd_data_a", rd_data_a, e_da);
        chk("rd_valid_a", W'(rd_valid_a), W'(e_va));
        chk("rd_data_b", rd_data_b, e_db);
        chk("rd_valid_b", W'(rd_valid_b), W'(e_vb));
        chk("busy", W'(busy), W'(m_busy));
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_busy = 1'b0; m_left = 0; m_idx = 0;
        e_da = '0; e_db = '0; e_va = 1'b0; e_vb = 1'b0;
    endtask

    function automatic bit write_takes();
        return wr_en && !(ZR && wr_addr == '0);
    endfunction

    function automatic logic [W-1:0] model_read(input logic [A-1:0] a);
        if (ZR && a == '0) return '0;
        if (write_takes() && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    // One clock edge of the reference behaviour, using the inputs held across it.
    task automatic model_edge();
        if (!m_busy) begin
            e_va = rd_en_a;
            e_vb = rd_en_b;
            if (rd_en_a) e_da = model_read(rd_addr_a);
            if (rd_en_b) e_db = model_read(rd_addr_b);
            if (write_takes()) m_mem[wr_addr] = wr_data;
            if (clr) begin
                m_busy = 1'b1; m_left = D; m_idx = 0;
            end
        end else begin
            e_va = 1'b0;
            e_vb = 1'b0;
            m_mem[m_idx] = '0;
            m_idx++;
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_in();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr = 1'b0;
    endtask

    task automatic rand_in(input int clr_pct);
        wr_en     = 1'($urandom_range(0, 1));
        wr_addr   = A'($urandom_range(0, D - 1));
        wr_data   = $urandom;
        rd_en_a   = 1'($urandom_range(0, 1));
        rd_en_b   = 1'($urandom_range(0, 1));
        rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : A'($urandom_range(0, D - 1));
        rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : A'($urandom_range(0, D - 1));
        clr       = ($urandom_range(0, 99) < clr_pct);
    endtask

    // Asserted off-edge; outputs must already be cleared before any clock edge.
    task automatic do_reset();
        idle_in();
        #2 rst = 1'b1;
        model_reset();
        #1 compare();
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    task automatic fill();
        idle_in();
        for (int i = 0; i < D; i++) begin
            wr_en = 1'b1; wr_addr = A'(i); wr_data = $urandom | 32'h1;
            cyc();
        end
        idle_in();
    endtask

    task automatic read_all();
        idle_in();
        for (int i = 0; i < D; i++) begin
            rd_en_a = 1'b1; rd_addr_a = A'(i);
            rd_en_b = 1'b1; rd_addr_b = A'(D - 1 - i);
            cyc();
        end
        idle_in();
    endtask

    int n;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Mid-run reset after random traffic.
        for (int i = 0; i < 40; i++) begin rand_in(0); cyc(); end
        do_reset();
        read_all();
        chk("reset_entry_lit", rd_data_a, 32'h0);

        // Write then read next cycle.
        idle_in();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        cyc();
        idle_in();
        rd_en_a = 1'b1; rd_addr_a = 5'd7;
        cyc();
        chk("wr_rd_lit", rd_data_a, 32'hDEADBEEF);
        chk("wr_rd_valid_lit", W'(rd_valid_a), 32'h1);
        idle_in();
        cyc();
        chk("valid_drop_lit", W'(rd_valid_a), 32'h0);
        chk("data_hold_lit", rd_data_a, 32'hDEADBEEF);

        // Bypass on both ports.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
        rd_en_a = 1'b1; rd_addr_a = 5'd3;
        rd_en_b = 1'b1; rd_addr_b = 5'd3;
        cyc();
        chk("bypass_a_lit", rd_data_a, 32'h12345678);
        chk("bypass_b_lit", rd_data_b, 32'h12345678);
        idle_in();

        // Full clear with traffic during the sequence.
        fill();
        clr = 1'b1;
        cyc();
        n = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            rand_in(50);
            cyc();
            if (!busy) break;
            n++;
        end
        chk("busy_len_lit", W'(n), 32'd32);
        read_all();
        chk("clear_entry_lit", rd_data_b, 32'h0);

        // Reset at clr_cnt == 10, then a fresh full clear.
        fill();
        clr = 1'b1;
        cyc();
        idle_in();
        for (int i = 0; i < 10; i++) cyc();
        do_reset();
        chk("busy_rst_lit", W'(busy), 32'h0);
        fill();
        clr = 1'b1;
        cyc();
        idle_in();
        n = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (!busy) break;
            n++;
        end
        chk("busy_len2_lit", W'(n), 32'd32);
        read_all();

        // Address 0 behaviour.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_en_a = 1'b1; rd_addr_a = 5'd0;
        cyc();
        chk("zero_same_lit", rd_data_a, ZR ? 32'h0 : 32'hFFFFFFFF);
        idle_in();
        rd_en_a = 1'b1; rd_addr_a = 5'd0;
        cyc();
        chk("zero_next_lit", rd_data_a, ZR ? 32'h0 : 32'hFFFFFFFF);
        chk("zero_valid_lit", W'(rd_valid_a), 32'h1);
        idle_in();

        // Random soak.
        for (int i = 0; i < 3000; i++) begin
            rand_in(2);
            cyc();
            if (i % 997 == 500) do_reset();
        end
        idle_in();
        for (int i = 0; i < 40; i++) cyc();
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
